// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the ALU shift path.
// Request bundle, stage-1 bundle and opcode encodings.
package alu_shift_pkg;

    localparam int DATA_W    = 32;
    localparam int SHAMT_W   = 5;
    localparam int REQ_TAG_W = 5;

    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [SHAMT_W-1:0]   shamt;
        logic                 op;
        logic [REQ_TAG_W-1:0] tag;
    } shift_req_t;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [2:0]           shamt;
        logic                 op;
        logic [REQ_TAG_W-1:0] tag;
    } s1_t;

endpackage

// File: rtl/shift_stage_fixed.sv
// One fixed-distance shift layer of the barrel shifter.
// SRA replicates the incoming MSB; SLL fills with zeros.
module shift_stage_fixed
    import alu_shift_pkg::*;
#(
    parameter int DIST  = 1,
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic             op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] sra;

    assign sll = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
    assign sra = {{DIST{din[WIDTH-1]}}, din[WIDTH-1:DIST]};

    always_comb begin
        dout = din;
        unique case (1'b1)
            (en && op == SHIFT_OP_SRA): dout = sra;
            (en && op == SHIFT_OP_SLL): dout = sll;
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_pipe_2stage.sv
// Two-stage pipelined SLL/SRA barrel shifter with valid/ready.
// Stage 1 shifts by 16/8, stage 2 (the output register) by 4/2/1.
module shift_pipe_2stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int TAG_W = REQ_TAG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_shamt,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    shift_req_t req;
    s1_t        s1_d;
    s1_t        s1_q;
    logic       s1_valid;
    logic       s1_adv;
    logic       s2_adv;
    logic       accept;

    logic [WIDTH-1:0] a16;
    logic [WIDTH-1:0] a8;
    logic [WIDTH-1:0] b4;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] b1;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid & in_ready;

    assign req = '{
        data:  in_data,
        shamt: in_shamt,
        op:    in_op,
        tag:   in_tag
    };

    shift_stage_fixed #(.DIST(16), .WIDTH(WIDTH)) u_sh16 (
        .en   (req.shamt[4]),
        .op   (req.op),
        .din  (req.data),
        .dout (a16)
    );

    shift_stage_fixed #(.DIST(8), .WIDTH(WIDTH)) u_sh8 (
        .en   (req.shamt[3]),
        .op   (req.op),
        .din  (a16),
        .dout (a8)
    );

    assign s1_d = '{
        data:  a8,
        shamt: req.shamt[2:0],
        op:    req.op,
        tag:   req.tag
    };

    // SRA sign survives stage 1 in bit 31, so stage 2 can reuse it
    shift_stage_fixed #(.DIST(4), .WIDTH(WIDTH)) u_sh4 (
        .en   (s1_q.shamt[2]),
        .op   (s1_q.op),
        .din  (s1_q.data),
        .dout (b4)
    );

    shift_stage_fixed #(.DIST(2), .WIDTH(WIDTH)) u_sh2 (
        .en   (s1_q.shamt[1]),
        .op   (s1_q.op),
        .din  (b4),
        .dout (b2)
    );

    shift_stage_fixed #(.DIST(1), .WIDTH(WIDTH)) u_sh1 (
        .en   (s1_q.shamt[0]),
        .op   (s1_q.op),
        .din  (b2),
        .dout (b1)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= b1;
                out_tag  <= s1_q.tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe_2stage.sv
// Bench for shift_pipe_2stage: directed vectors plus a queue model
// checked on every output transfer and every stalled cycle.
module tb_shift_pipe_2stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic        in_op = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    shift_pipe_2stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   seen_tag[$];
    int   seen_cyc[$];

    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [4:0]  hold_t;

    function automatic logic [31:0] model(logic [31:0] a, int sh, logic op);
        if (op)
            return 32'($signed(a) >>> sh);
        return a << sh;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Sample away from the active edge; transfers seen here land on the next posedge
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, hold_d);
                chk("hold_tag", 32'(out_tag), 32'(hold_t));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_tag), 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("model_data", out_data, e.d);
                    chk("model_tag", 32'(out_tag), 32'(e.t));
                end
                seen_tag.push_back(int'(out_tag));
                seen_cyc.push_back(cyc);
            end
            if (in_valid && in_ready)
                exp_q.push_back('{model(in_data, int'(in_shamt), in_op), in_tag});
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic [31:0] a, logic [4:0] sh, logic op, logic [4:0] t);
        in_data  = a;
        in_shamt = sh;
        in_op    = op;
        in_tag   = t;
    endtask

    task automatic send(logic [31:0] a, logic [4:0] sh, logic op, logic [4:0] t);
        bit ok;
        ok = 0;
        drive(a, sh, op, t);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (in_ready)
                ok = 1;
        end
        chk("send_ready", 32'(ok), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic single(logic [31:0] a, logic [4:0] sh, logic op,
                          logic [4:0] t, logic [31:0] exp);
        out_ready = 1'b1;
        send(a, sh, op, t);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("direct_data", out_data, exp);
        chk("direct_tag", 32'(out_tag), 32'(t));
        step();
        step();
    endtask

    logic [31:0] bp_a[4] = '{32'hDEAD_BEEF, 32'h8000_1234, 32'h0000_00FF, 32'hC0DE_0001};
    logic [4:0]  bp_s[4] = '{5'd3, 5'd20, 5'd9, 5'd31};
    logic        bp_o[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int   idx;
        bit   acc;
        logic [31:0] hd;
        logic [4:0]  ht;

        chk("pin_sll31", model(32'h0000_0001, 31, 1'b0), 32'h8000_0000);
        chk("pin_sra31", model(32'h8000_0000, 31, 1'b1), 32'hFFFF_FFFF);
        chk("pin_sra4", model(32'h7FFF_FFF0, 4, 1'b1), 32'h07FF_FFFF);

        in_valid = 1'b1;
        drive(32'hFFFF_FFFF, 5'd1, 1'b0, 5'd9);
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_out_data", out_data, 32'd0);
        chk("rel_out_tag", 32'(out_tag), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        single(32'h0000_0001, 5'd31, 1'b0, 5'd1, 32'h8000_0000);
        single(32'hF000_000F, 5'd4, 1'b0, 5'd2, 32'h0000_00F0);
        single(32'h8000_0000, 5'd31, 1'b1, 5'd3, 32'hFFFF_FFFF);
        single(32'h7FFF_FFF0, 5'd4, 1'b1, 5'd4, 32'h07FF_FFFF);
        single(32'h9234_5678, 5'd0, 1'b1, 5'd5, 32'h9234_5678);
        single(32'h9234_5678, 5'd0, 1'b0, 5'd6, 32'h9234_5678);
        single(32'h8765_4321, 5'd13, 1'b1, 5'd7, 32'hFFFC_3B2A);

        seen_tag.delete();
        seen_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h8123_4567 ^ (32'(i) << 28), 5'(i * 4 + 1), i[0], 5'(i));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("b2b_count", 32'(seen_tag.size()), 32'd8);
        if (seen_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_tag", 32'(seen_tag[i]), 32'(i));
                chk("b2b_cycle", 32'(seen_cyc[i] - seen_cyc[0]), 32'(i));
            end
        end

        seen_tag.delete();
        out_ready = 1'b0;
        idx = 0;
        drive(bp_a[0], bp_s[0], bp_o[0], 5'd10);
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            acc = in_ready;
            step();
            if (acc) begin
                idx++;
                drive(bp_a[idx], bp_s[idx], bp_o[idx], 5'(10 + idx));
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        hd = out_data;
        ht = out_tag;
        chk("bp_head_data", hd, model(bp_a[0], 3, 1'b1));
        repeat (5) begin
            step();
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            chk("bp_stall_data", out_data, hd);
            chk("bp_stall_tag", 32'(out_tag), 32'(ht));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clock);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 4)
                    drive(bp_a[idx], bp_s[idx], bp_o[idx], 5'(10 + idx));
                else
                    in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_outs", 32'(seen_tag.size()), 32'd4);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        if (seen_tag.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("bp_order", 32'(seen_tag[i]), 32'(10 + i));

        seen_tag.delete();
        out_ready = 1'b0;
        send(32'h0000_00AA, 5'd2, 1'b0, 5'd20);
        send(32'h0000_00BB, 5'd3, 1'b0, 5'd21);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("mid_rst_quiet", 32'(out_valid), 32'd0);
        end
        chk("mid_rst_none", 32'(seen_tag.size()), 32'd0);
        single(32'h0000_0003, 5'd5, 1'b0, 5'd22, 32'h0000_0060);
        chk("mid_rst_after", 32'(seen_tag.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
